wb_sdr_arbiter: RTL and testbench
=================================

WB_SDR_ARBITER -- requirements
Module: wb_sdr_arbiter

Interface
REQ-001 SHALL have parameter dw, default 32, Wishbone data width in bits; dw is a multiple of 8.
REQ-002 SHALL have parameter app_addr_w, default 26, Wishbone address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait for slave ack in cycles; legal range 2..255.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port sys_rst, input, 1 bit: asynchronous reset, active-high.
REQ-007 For each master N in {0,1}, port mN_cyc_i, input, 1 bit: master N bus cycle request.
REQ-008 For each N, port mN_stb_i, input, 1 bit: master N strobe.
REQ-009 For each N, port mN_we_i, input, 1 bit: master N write enable.
REQ-010 For each N, port mN_sel_i, input, dw/8 bits: master N byte selects.
REQ-011 For each N, port mN_adr_i, input, app_addr_w bits: master N address.
REQ-012 For each N, port mN_dat_i, input, dw bits: master N write data.
REQ-013 For each N, port mN_dat_o, output, dw bits: read data to master N.
REQ-014 For each N, port mN_ack_o, output, 1 bit: transfer acknowledge to master N.
REQ-015 For each N, port mN_err_o, output, 1 bit: timeout error to master N.
REQ-016 Slave-side ports s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o SHALL be outputs with the widths of the matching master inputs, driving the SDRAM controller Wishbone port.
REQ-017 Ports s_dat_i (input, dw bits) and s_ack_i (input, 1 bit) SHALL carry read data and acknowledge from the SDRAM controller.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, GNT0, GNT1; state, last-served flag and timeout counter are registered.
REQ-019 In IDLE with exactly one mN_cyc_i high, next state SHALL be GNTN.
REQ-020 In IDLE with both cyc high, next state SHALL be GNT of the master not last served (round-robin).
REQ-021 In IDLE with neither cyc high, state SHALL remain IDLE.
REQ-022 Latency SHALL be: request sampled in IDLE at edge k; s_cyc_o high from edge k+1.
REQ-023 In GNTN, slave outputs SHALL equal master N signals combinationally (s_cyc_o=mN_cyc_i, s_stb_o=mN_stb_i, etc.).
REQ-024 In IDLE, all s_* outputs SHALL be 0.
REQ-025 In GNTN, mN_ack_o SHALL equal s_ack_i; the other master's ack_o SHALL be 0.
REQ-026 Both mN_dat_o SHALL equal s_dat_i at all times.
REQ-027 Grant SHALL be held across multiple stb/ack transfers while the granted master holds cyc high; no preemption occurs.
REQ-028 In GNTN, when mN_cyc_i is low, next state SHALL be IDLE and last-served SHALL be N.
REQ-029 The IDLE state gives one dead cycle between grants; back-to-back grants to different masters are not permitted.
REQ-030 Timeout counter SHALL clear on any state change and on each s_ack_i.
REQ-031 Timeout counter SHALL increment each cycle in GNTN while s_stb_o=1 and s_ack_i=0, saturating at TIMEOUT.
REQ-032 On the cycle the counter equals TIMEOUT, mN_err_o SHALL pulse high for exactly 1 cycle.
REQ-033 On that timeout cycle, s_cyc_o and s_stb_o SHALL be forced to 0, mN_ack_o SHALL be 0, and next state SHALL be IDLE with last-served=N.
REQ-034 If s_ack_i and the timeout condition coincide, ack SHALL win: no err, counter clears.
REQ-035 The ungranted master's request SHALL be ignored until the FSM returns to IDLE; its cyc may stay high indefinitely without effect.

Reset
REQ-036 While sys_rst=1, state SHALL be IDLE, last-served SHALL be 1, counter SHALL be 0, and all ack/err/s_* outputs SHALL be 0.
REQ-037 Reset asserted mid-transfer SHALL drop s_cyc_o immediately (asynchronously), and no ack/err SHALL reach any master.
REQ-038 After reset release, with both masters requesting, m0 SHALL be granted first.

Verification
REQ-039 Scenario: reset, then m0 and m1 cyc high together at cycle 0 -> s_cyc_o follows m0 from cycle 1; m0 drops cyc at cycle 5 -> IDLE at 6, GNT1 at 7.
REQ-040 Scenario: m1 alone issues a 4-beat burst, slave acks each cycle -> 4 m1_ack_o pulses, m0_ack_o stays 0, grant held for all 4 beats.
REQ-041 Scenario: TIMEOUT=4, slave never acks m0 -> m0_err_o high for exactly 1 cycle, 4 cycles after stb; s_cyc_o low that cycle; then IDLE.
REQ-042 Scenario: TIMEOUT=4, ack arrives on the 4th wait cycle -> m0_ack_o=1, m0_err_o=0.
REQ-043 Scenario: sys_rst pulsed during GNT1 read -> s_cyc_o=0 without waiting for a clock edge; after release with both requesting, m0 is granted.
REQ-044 Scenario: continuous requests from both masters for 10 transactions -> grants strictly alternate m0, m1, m0, and so on.

Source files
------------

// File: rtl/wb_sdr_arbiter.sv
// Two-master Wishbone arbiter in front of an SDRAM controller port.
// Round-robin grant with a dead IDLE cycle between owners and an ack-timeout that
// aborts a stalled transfer and reports it to the owning master.
module wb_sdr_arbiter #(
    parameter int unsigned dw         = 32,
    parameter int unsigned app_addr_w = 26,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [dw/8-1:0]       m0_sel_i,
    input  logic [app_addr_w-1:0] m0_adr_i,
    input  logic [dw-1:0]         m0_dat_i,
    output logic [dw-1:0]         m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [dw/8-1:0]       m1_sel_i,
    input  logic [app_addr_w-1:0] m1_adr_i,
    input  logic [dw-1:0]         m1_dat_i,
    output logic [dw-1:0]         m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [dw/8-1:0]       s_sel_o,
    output logic [app_addr_w-1:0] s_adr_o,
    output logic [dw-1:0]         s_dat_o,
    input  logic [dw-1:0]         s_dat_i,
    input  logic                  s_ack_i
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       expired;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // An ack arriving on the expiry cycle still completes the transfer.
    assign expired = (cnt_q == TimeoutCnt) && !s_ack_i;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                if (expired) begin
                    m0_err_o = 1'b1;
                    s_cyc_o  = 1'b0;
                    s_stb_o  = 1'b0;
                    state_d  = StIdle;
                    last_d   = 1'b0;
                end else if (!m0_cyc_i) begin
                    state_d = StIdle;
                    last_d  = 1'b0;
                end
            end
            StGnt1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                if (expired) begin
                    m1_err_o = 1'b1;
                    s_cyc_o  = 1'b0;
                    s_stb_o  = 1'b0;
                    state_d  = StIdle;
                    last_d   = 1'b1;
                end else if (!m1_cyc_i) begin
                    state_d = StIdle;
                    last_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_d != state_q) || s_ack_i) begin
            cnt_d = '0;
        end else if ((state_q != StIdle) && s_stb_o && (cnt_q != TimeoutCnt)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_sdr_arbiter.sv
// Bench for wb_sdr_arbiter: vector table plus hand sequences for timeout, async reset
// and round-robin alternation; expectations go through a queue and are checked per cycle.
module tb_wb_sdr_arbiter;

    localparam int DW = 32;
    localparam int AW = 26;

    localparam logic          M0_WE  = 1'b1;
    localparam logic [3:0]    M0_SEL = 4'hF;
    localparam logic [AW-1:0] M0_ADR = 26'h0000111;
    localparam logic [DW-1:0] M0_DAT = 32'hA0A0_5555;
    localparam logic          M1_WE  = 1'b0;
    localparam logic [3:0]    M1_SEL = 4'h3;
    localparam logic [AW-1:0] M1_ADR = 26'h0000222;
    localparam logic [DW-1:0] M1_DAT = 32'hB1B1_AAAA;

    // g: 0 = nothing granted (slave side all zero), 1 = m0 owns bus, 2 = m1 owns bus
    typedef struct packed {
        logic c0, s0, c1, s1, ack;
        logic [1:0] g;
        logic a0, a1, e0, e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_cyc = 1'b0, m0_stb = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic s_ack = 1'b0;
    logic [DW-1:0] s_dat = '0;
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic s_cyc_o, s_stb_o, s_we_o;
    logic [3:0] s_sel_o;
    logic [AW-1:0] s_adr_o;

    int checks = 0;
    int errors = 0;

    vec_t          exp_q[$];
    logic [DW-1:0] dat_q[$];
    string         tag_q[$];

    always #5 clk = ~clk;

    wb_sdr_arbiter #(.dw(DW), .app_addr_w(AW), .TIMEOUT(4)) dut (
        .sys_clk (clk),      .sys_rst (rst),
        .m0_cyc_i(m0_cyc),   .m0_stb_i(m0_stb),   .m0_we_i(M0_WE),
        .m0_sel_i(M0_SEL),   .m0_adr_i(M0_ADR),   .m0_dat_i(M0_DAT),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc),   .m1_stb_i(m1_stb),   .m1_we_i(M1_WE),
        .m1_sel_i(M1_SEL),   .m1_adr_i(M1_ADR),   .m1_dat_i(M1_DAT),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o (s_cyc_o),  .s_stb_o (s_stb_o),  .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),  .s_adr_o (s_adr_o),  .s_dat_o (s_dat_o),
        .s_dat_i (s_dat),    .s_ack_i (s_ack)
    );

    function automatic vec_t mk(input logic c0, s0, c1, s1, ack, input logic [1:0] g,
                                input logic a0, a1, e0, e1);
        vec_t v;
        v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.g = g;
        v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(input vec_t v, input logic [DW-1:0] sd, input string tag);
        logic [64:0] exp_s, act_s;
        case (v.g)
            2'd1:    exp_s = {v.c0, v.s0, M0_WE, M0_SEL, M0_ADR, M0_DAT};
            2'd2:    exp_s = {v.c1, v.s1, M1_WE, M1_SEL, M1_ADR, M1_DAT};
            default: exp_s = '0;
        endcase
        if (v.e0 || v.e1) exp_s[64:63] = 2'b00;
        act_s = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o};
        chk({tag, " slave"}, 128'(act_s), 128'(exp_s));
        chk({tag, " ack/err"}, 128'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}),
            128'({v.a0, v.a1, v.e0, v.e1}));
        chk({tag, " dat_o"}, 128'({m0_dat_o, m1_dat_o}), 128'({sd, sd}));
    endtask

    task automatic step(input vec_t v, input string tag);
        logic [DW-1:0] sd;
        @(posedge clk);
        #1;
        m0_cyc = v.c0; m0_stb = v.s0; m1_cyc = v.c1; m1_stb = v.s1; s_ack = v.ack;
        sd = $urandom;
        s_dat = sd;
        exp_q.push_back(v);
        dat_q.push_back(sd);
        tag_q.push_back(tag);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            compare(exp_q.pop_front(), dat_q.pop_front(), tag_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[21];
        int   exp_g;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 1, 1, 2, 0, 1, 0, 0);
        tbl[8]  = mk(1, 1, 1, 1, 1, 2, 0, 1, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 15; i < 19; i++) tbl[i] = mk(0, 0, 1, 1, 1, 2, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Outputs held quiet during reset even with every input active.
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        s_dat = 32'h1234_5678;
        repeat (2) @(negedge clk);
        compare(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0), s_dat, "in_reset");
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
        rst = 0;

        for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("vec%0d", i));

        // m0 stalls: err on the 5th granted cycle, one cycle only.
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "to0_req");
        for (int i = 0; i < 4; i++) step(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "to0_wait");
        step(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 0), "to0_err");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to0_idle");

        // Ack on the 4th wait cycle, then ack exactly on the expiry cycle.
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "ack4_req");
        for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "ack4_wait");
        step(mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 0), "ack4_ack");
        for (int i = 0; i < 4; i++) step(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "ackto_wait");
        step(mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 0), "ackto_win");
        step(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "ackto_clr");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "ackto_drop");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ackto_idle");

        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "to1_req");
        for (int i = 0; i < 4; i++) step(mk(0, 0, 1, 1, 0, 2, 0, 0, 0, 0), "to1_wait");
        step(mk(0, 0, 1, 1, 0, 2, 0, 0, 0, 1), "to1_err");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to1_idle");

        // Reset in the middle of an m1 read must drop the bus without a clock edge.
        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "rst_req");
        step(mk(0, 0, 1, 1, 0, 2, 0, 0, 0, 0), "rst_gnt1");
        #1;
        rst = 1; s_ack = 1; m0_cyc = 1; m0_stb = 1;
        #1;
        compare(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0), s_dat, "rst_async");
        @(posedge clk);
        #1;
        compare(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0), s_dat, "rst_hold");
        @(negedge clk);
        rst = 0; s_ack = 0;
        step(mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 0), "rst_m0_first");
        step(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0), "rst_m0_drop");
        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "rst_idle");
        step(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0), "rst_m1_drop");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_end");

        // Both masters keep requesting: grants must alternate starting with m0.
        @(negedge clk);
        rst = 1; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        rst = 0;
        exp_g = 1;
        for (int t = 0; t < 10; t++) begin
            if (exp_g == 1) begin
                step(mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0), $sformatf("rr%0d_m0", t));
                step(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0), $sformatf("rr%0d_drop", t));
            end else begin
                step(mk(1, 1, 1, 1, 1, 2, 0, 1, 0, 0), $sformatf("rr%0d_m1", t));
                step(mk(1, 1, 0, 0, 0, 2, 0, 0, 0, 0), $sformatf("rr%0d_drop", t));
            end
            step(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0), $sformatf("rr%0d_idle", t));
            exp_g = (exp_g == 1) ? 2 : 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
